// File: rtl/pll_sup_pkg.sv
// Shared types and helpers for the PLL clock supervisor.
// State encoding is fixed because it is exported on the debug state port.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    FILTER    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4,
    FAIL      = 3'd5
  } state_t;

  localparam int RETRY_W = 4;

  // Width of the shared sequencing counter: wide enough for the longest dwell.
  function automatic int cnt_width(input int reset_pulse, input int lock_filter,
                                   input int relock_timeout, input int stagger,
                                   input int num_ch);
    int m;
    m = reset_pulse;
    if (lock_filter > m)      m = lock_filter;
    if (relock_timeout > m)   m = relock_timeout;
    if (stagger > m)          m = stagger;
    if (num_ch * stagger > m) m = num_ch * stagger;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/pll_sup_sync.sv
// Two-flop synchroniser bringing the asynchronous PLL lock into the
// reference-clock domain. Two cycles of latency from d to q.
module pll_sup_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Metastability filter: two back-to-back flops, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_clock_supervisor.sv
// PLL clock supervisor: pulses the PLL reset, qualifies lock through a
// stability filter, retries or fails on lock timeout, then releases domain
// resets in a staggered sequence. Lock loss re-runs the whole sequence.
// Optional feature macro: PLL_SUP_ICEGATE_EN enables per-channel clock
// gating from gate_req while in RUN (one cycle of latency).
// All outputs come from registers; the debug state port mirrors the FSM.
module pll_clock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int NUM_CH         = 3,
  parameter int RESET_PULSE    = 4,
  parameter int LOCK_FILTER    = 16,
  parameter int RELOCK_TIMEOUT = 64,
  parameter int MAX_RETRIES    = 2,
  parameter int STAGGER        = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               lock,
  input  logic [NUM_CH-1:0]  gate_req,
  output logic               pll_reset,
  output logic               locked,
  output logic [NUM_CH-1:0]  domain_reset,
  output logic [NUM_CH-1:0]  clk_en,
  output logic               fail,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic [2:0]         state
);

  localparam int CW = cnt_width(RESET_PULSE, LOCK_FILTER, RELOCK_TIMEOUT,
                                STAGGER, NUM_CH);

  // Counter value on the last cycle of each timed dwell.
  localparam logic [CW-1:0] RP_END  = CW'(RESET_PULSE - 1);
  localparam logic [CW-1:0] LF_END  = CW'(LOCK_FILTER - 1);
  localparam logic [CW-1:0] RT_END  = CW'(RELOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] REL_END = CW'(NUM_CH * STAGGER - 1);

  logic lock_s;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;

  logic              pll_reset_q, pll_reset_d;
  logic              locked_q, locked_d;
  logic              fail_q, fail_d;
  logic [NUM_CH-1:0] dr_q, dr_d;
  logic [NUM_CH-1:0] en_q, en_d;

  pll_sup_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (lock),
    .q     (lock_s)
  );

  // Next-state logic: timeouts, retries and lock-loss re-sequencing.
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    unique case (state_q)
      PLL_RST: begin
        if (cnt_q == RP_END) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_d = FILTER;
        end else if (cnt_q == RT_END) begin
          retry_d = (retry_q == '1) ? retry_q : retry_q + RETRY_W'(1);
          state_d = (retry_q == RETRY_W'(MAX_RETRIES)) ? FAIL : PLL_RST;
        end
      end
      FILTER: begin
        if (!lock_s)               state_d = WAIT_LOCK;
        else if (cnt_q == LF_END)  state_d = RELEASE;
      end
      RELEASE: begin
        if (!lock_s) begin
          state_d = PLL_RST;
        end else if (cnt_q == REL_END) begin
          state_d = RUN;
          retry_d = '0;
        end
      end
      RUN: begin
        if (!lock_s) state_d = PLL_RST;
      end
      FAIL: begin
        state_d = FAIL;
      end
      default: state_d = PLL_RST;
    endcase
  end

  // Shared counter and registered-output next values, derived from next state
  // so every output lines up with the state it belongs to.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q)                   cnt_d = '0;
    else if (state_q != RUN && state_q != FAIL) cnt_d = cnt_q + CW'(1);

    pll_reset_d = (state_d == PLL_RST) || (state_d == FAIL);
    locked_d    = (state_d == RELEASE) || (state_d == RUN);
    fail_d      = (state_d == FAIL);
    en_d        = {NUM_CH{locked_d}};
    dr_d        = '1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (state_d == RELEASE)  dr_d[i] = (int'(cnt_d) < (i + 1) * STAGGER);
      else if (state_d == RUN) dr_d[i] = 1'b0;
    end
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= PLL_RST;
      cnt_q       <= '0;
      retry_q     <= '0;
      pll_reset_q <= 1'b1;
      locked_q    <= 1'b0;
      fail_q      <= 1'b0;
      dr_q        <= '1;
      en_q        <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      pll_reset_q <= pll_reset_d;
      locked_q    <= locked_d;
      fail_q      <= fail_d;
      dr_q        <= dr_d;
      en_q        <= en_d;
    end
  end

`ifdef PLL_SUP_ICEGATE_EN
  logic [NUM_CH-1:0] gate_q;

  // Gate request register; only consulted while in RUN.
  always_ff @(posedge clk) begin
    if (reset) gate_q <= '0;
    else       gate_q <= gate_req;
  end

  assign clk_en = (state_q == RUN) ? (en_q & ~gate_q) : en_q;
`else
  logic unused_gate_req;
  assign unused_gate_req = ^gate_req;
  assign clk_en          = en_q;
`endif

  assign pll_reset    = pll_reset_q;
  assign locked       = locked_q;
  assign domain_reset = dr_q;
  assign fail         = fail_q;
  assign retry_cnt    = retry_q;
  assign state        = state_q;

endmodule

// File: tb/tb_pll_clock_supervisor.sv
// Bench for pll_clock_supervisor: directed scenarios followed by a randomised
// lock/reset/gate soak, every cycle compared against an elapsed-time model.
module tb_pll_clock_supervisor;

  localparam int NUM_CH         = 3;
  localparam int RESET_PULSE    = 4;
  localparam int LOCK_FILTER    = 16;
  localparam int RELOCK_TIMEOUT = 64;
  localparam int MAX_RETRIES    = 2;
  localparam int STAGGER        = 8;

  localparam int P_PLL_RST = 0;
  localparam int P_WAIT    = 1;
  localparam int P_FILTER  = 2;
  localparam int P_RELEASE = 3;
  localparam int P_RUN     = 4;
  localparam int P_FAIL    = 5;

  // clock / reset block
  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              lock = 1'b0;
  logic [NUM_CH-1:0] gate_req = '0;
  logic              pll_reset, locked, fail;
  logic [NUM_CH-1:0] domain_reset, clk_en;
  logic [3:0]        retry_cnt;
  logic [2:0]        state;

  always #5 clk = ~clk;

  pll_clock_supervisor #(
    .NUM_CH(NUM_CH), .RESET_PULSE(RESET_PULSE), .LOCK_FILTER(LOCK_FILTER),
    .RELOCK_TIMEOUT(RELOCK_TIMEOUT), .MAX_RETRIES(MAX_RETRIES), .STAGGER(STAGGER)
  ) dut (
    .clk(clk), .reset(reset), .lock(lock), .gate_req(gate_req),
    .pll_reset(pll_reset), .locked(locked), .domain_reset(domain_reset),
    .clk_en(clk_en), .fail(fail), .retry_cnt(retry_cnt), .state(state)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // reference model: phase, edge at which it was entered, retries, lock delay line
  int                m_phase = P_PLL_RST;
  int                m_enter = 0;
  int                m_retry = 0;
  bit                m_hist[$];
  logic [NUM_CH-1:0] m_gate_q = '0;

  // scoreboard of per-cycle expectations
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void m_go(input int p);
    m_phase = p;
    m_enter = cyc;
  endfunction

  // Advance the model by one clock edge using the inputs sampled at that edge.
  task automatic model_edge();
    bit ls;
    int spent;
    if (reset) begin
      m_go(P_PLL_RST);
      m_retry  = 0;
      m_hist   = {1'b0, 1'b0};
      m_gate_q = '0;
    end else begin
      ls = m_hist[0];
      m_hist.delete(0);
      m_hist.push_back(lock);
      spent = cyc - m_enter;
      case (m_phase)
        P_PLL_RST: if (spent == RESET_PULSE) m_go(P_WAIT);
        P_WAIT: begin
          if (ls) m_go(P_FILTER);
          else if (spent == RELOCK_TIMEOUT) begin
            if (m_retry == MAX_RETRIES) m_go(P_FAIL);
            else                        m_go(P_PLL_RST);
            m_retry = (m_retry < 15) ? m_retry + 1 : 15;
          end
        end
        P_FILTER: begin
          if (!ls)                        m_go(P_WAIT);
          else if (spent == LOCK_FILTER)  m_go(P_RELEASE);
        end
        P_RELEASE: begin
          if (!ls) m_go(P_PLL_RST);
          else if (spent == NUM_CH * STAGGER) begin
            m_go(P_RUN);
            m_retry = 0;
          end
        end
        P_RUN: if (!ls) m_go(P_PLL_RST);
        default: ;
      endcase
      m_gate_q = gate_req;
    end
  endtask

  function automatic logic [15:0] m_expect();
    logic              pr, lk;
    logic [NUM_CH-1:0] dr, en;
    int                el;
    el = cyc - m_enter;
    pr = (m_phase == P_PLL_RST) || (m_phase == P_FAIL);
    lk = (m_phase == P_RELEASE) || (m_phase == P_RUN);
    for (int i = 0; i < NUM_CH; i++) begin
      if (m_phase == P_RELEASE) dr[i] = (el < (i + 1) * STAGGER);
      else                      dr[i] = (m_phase != P_RUN);
    end
    en = lk ? '1 : '0;
`ifdef PLL_SUP_ICEGATE_EN
    if (m_phase == P_RUN) en = ~m_gate_q;
`endif
    return {pr, lk, dr, en, (m_phase == P_FAIL), 4'(m_retry), 3'(m_phase)};
  endfunction

  function automatic logic [15:0] dut_obs();
    return {pll_reset, locked, domain_reset, clk_en, fail, retry_cnt, state};
  endfunction

  function automatic int get_sig(input int sel);
    case (sel)
      0:       return int'(pll_reset);
      1:       return int'(locked);
      2:       return int'(domain_reset[0]);
      3:       return int'(domain_reset[1]);
      4:       return int'(domain_reset[2]);
      5:       return int'(fail);
      6:       return int'(state);
      7:       return int'(retry_cnt);
      default: return int'(domain_reset);
    endcase
  endfunction

  // driver: one clock, model update, then compare just after the edge
  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    exp_q.push_back(m_expect());
    #1;
    check("cycle", 32'(dut_obs()), 32'(exp_q.pop_front()));
  endtask

  // Step until a signal reaches a value, bounded; the final value is checked.
  task automatic wait_sig(input string tag, input int sel, input int val,
                          input int limit, output int n);
    n = 0;
    while (get_sig(sel) != val && n < limit) begin
      step();
      n++;
    end
    check(tag, 32'(get_sig(sel)), 32'(val));
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_pll_reset"}, 32'(pll_reset), 32'd1);
    check({pfx, "_locked"},    32'(locked),    32'd0);
    check({pfx, "_dom_reset"}, 32'(domain_reset), 32'h7);
    check({pfx, "_clk_en"},    32'(clk_en),    32'd0);
    check({pfx, "_fail"},      32'(fail),      32'd0);
    check({pfx, "_retry"},     32'(retry_cnt), 32'd0);
    check({pfx, "_state"},     32'(state),     32'(P_PLL_RST));
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n, n1, n2, n3, hold;
    m_hist = {1'b0, 1'b0};

    // nominal lock-up: LOCK rises 10 cycles after PLL reset falls
    repeat (3) step();
    check_reset_values("rst");
    reset = 1'b0;
    wait_sig("pll_reset_fall", 0, 0, 20, n);
    check("pll_reset_width", 32'(n), 32'(RESET_PULSE));
    repeat (10) step();
    lock = 1'b1;
    wait_sig("locked_rise", 1, 1, 100, n);
    check("lock_to_locked", 32'(n), 32'(2 + 1 + LOCK_FILTER));
    wait_sig("dr0_fall", 2, 0, 100, n1);
    wait_sig("dr1_fall", 3, 0, 100, n2);
    wait_sig("dr2_fall", 4, 0, 100, n3);
    check("dr0_delay", 32'(n1), 32'(STAGGER));
    check("dr1_delay", 32'(n1 + n2), 32'(2 * STAGGER));
    check("dr2_delay", 32'(n1 + n2 + n3), 32'(3 * STAGGER));
    check("state_run", 32'(state), 32'(P_RUN));

`ifdef PLL_SUP_ICEGATE_EN
    gate_req = 3'b010;
    step();
    check("gate_clk_en", 32'(clk_en), 32'h5);
    check("gate_dom_reset", 32'(domain_reset), 32'h0);
    gate_req = 3'b000;
    step();
    check("ungate_clk_en", 32'(clk_en), 32'h7);
`endif

    // lock loss in RUN
    repeat (5) step();
    lock = 1'b0;
    wait_sig("drop_dom_reset", 8, 7, 10, n);
    check("drop_latency", 32'(n), 32'd3);
    check("drop_clk_en", 32'(clk_en), 32'd0);
    check("drop_locked", 32'(locked), 32'd0);
    check("drop_state", 32'(state), 32'(P_PLL_RST));
    check("drop_retry", 32'(retry_cnt), 32'd0);
    lock = 1'b1;
    wait_sig("reseq_run", 6, P_RUN, 300, n);

    // lock never arrives: retries then FAIL
    reset = 1'b1;
    lock  = 1'b0;
    repeat (2) step();
    reset = 1'b0;
    wait_sig("retry1", 7, 1, 200, n);
    check("retry1_time", 32'(n), 32'(RESET_PULSE + RELOCK_TIMEOUT));
    wait_sig("retry2", 7, 2, 200, n);
    check("retry2_time", 32'(n), 32'(RESET_PULSE + RELOCK_TIMEOUT));
    wait_sig("fail_rise", 5, 1, 200, n);
    check("fail_time", 32'(n), 32'(RESET_PULSE + RELOCK_TIMEOUT));
    check("fail_pll_reset", 32'(pll_reset), 32'd1);
    check("fail_retry", 32'(retry_cnt), 32'(MAX_RETRIES + 1));
    lock = 1'b1;
    repeat (40) step();
    check("fail_sticky", 32'(fail), 32'd1);
    check("fail_state", 32'(state), 32'(P_FAIL));

    // single-cycle glitch at FILTER count 10
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    wait_sig("filter_enter", 6, P_FILTER, 100, n);
    repeat (8) step();
    lock = 1'b0;
    step();
    lock = 1'b1;
    wait_sig("glitch_wait", 6, P_WAIT, 5, n);
    check("glitch_retry", 32'(retry_cnt), 32'd0);
    wait_sig("refilter", 6, P_FILTER, 10, n);
    wait_sig("requalify", 1, 1, 40, n);
    check("requalify_len", 32'(n), 32'(LOCK_FILTER));

    // gate requests in RELEASE are ignored; then reset mid-RELEASE
    gate_req = 3'b101;
    wait_sig("rel_dr0_fall", 2, 0, 40, n);
    check("rel_gate_ignored", 32'(clk_en), 32'h7);
    gate_req = 3'b000;
    repeat (2) step();
    reset = 1'b1;
    step();
    check_reset_values("midrel");
    reset = 1'b0;

    // randomised soak
    hold = 0;
    for (int c = 0; c < 4000; c++) begin
      if (hold == 0) begin
        lock = ~lock;
        hold = lock ? int'($urandom_range(10, 200)) : int'($urandom_range(1, 80));
      end
      hold--;
      if ($urandom_range(0, 3) == 0) gate_req = NUM_CH'($urandom_range(0, 7));
      reset = ($urandom_range(0, 299) == 0) ||
              (m_phase == P_FAIL && (cyc - m_enter) > 30);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pll_clock_supervisor.md
# pll_clock_supervisor

Sequencer that sits beside the iCE40UP PLL wrapper and runs on the free-running pad reference clock. It pulses the PLL reset, qualifies LOCK with a stability filter, and retries or declares failure on lock timeout. It then releases per-domain resets in a staggered sequence and provides per-channel iCEGate-style clock enables. Lock loss is detected at any time after qualification and triggers a full re-sequence.

## Interface
Parameters:
- NUM_CH, 3: number of downstream clock/reset domains, 1..8.
- RESET_PULSE, 4: cycles PLL_RESET is held high per attempt, ≥1.
- LOCK_FILTER, 16: consecutive synchronised-LOCK-high cycles needed to qualify, ≥1.
- RELOCK_TIMEOUT, 64: cycles allowed in WAIT_LOCK before an attempt fails, ≥1.
- MAX_RETRIES, 2: failed attempts allowed before FAIL, 0..15.
- STAGGER, 8: cycles between successive domain reset releases, ≥1.

Ports:
- CLK  in  1  reference (pad) clock. All logic runs in this single domain.
- RESET  in  1  synchronous, active-high.
- LOCK  in  1  PLL lock, asynchronous. Synchronised internally.
- GATE_REQ  in  NUM_CH  per-channel clock-gate request, level.
- PLL_RESET  out  1  drives the PLL reset, active-high.
- LOCKED  out  1  qualified lock.
- DOMAIN_RESET  out  NUM_CH  per-domain reset, active-high.
- CLK_EN  out  NUM_CH  per-domain clock enable.
- FAIL  out  1  sticky; asserts when retries are exhausted.
- RETRY_CNT  out  4  failed attempts since the last RUN.
- STATE  out  3  current FSM state, for debug.

## Operation
- Reset values: PLL_RESET=1, LOCKED=0, DOMAIN_RESET=all 1, CLK_EN=0, FAIL=0, RETRY_CNT=0, STATE=PLL_RST, counter=0.
- LOCK passes through a 2-flop synchroniser; lock_s is the synchronised signal. All FSM decisions use lock_s.
- FSM states and transitions:
  - PLL_RST: PLL_RESET=1 for RESET_PULSE cycles, then go to WAIT_LOCK.
  - WAIT_LOCK: PLL_RESET=0. If lock_s=1, go to FILTER. If the counter reaches RELOCK_TIMEOUT, increment RETRY_CNT; go to FAIL if RETRY_CNT already equals MAX_RETRIES, otherwise go to PLL_RST.
  - FILTER: counts consecutive lock_s=1 cycles. If lock_s=0, go to WAIT_LOCK with the timeout count restarted. At LOCK_FILTER, go to RELEASE.
  - RELEASE: LOCKED=1 and CLK_EN=all 1. DOMAIN_RESET[i] deasserts when the counter reaches (i+1)*STAGGER. After NUM_CH*STAGGER cycles, go to RUN and clear RETRY_CNT.
  - RUN: steady state.
  - FAIL: PLL_RESET=1, DOMAIN_RESET=all 1, CLK_EN=0, FAIL=1. Exit only via RESET.
- Lock loss (lock_s=0 in RELEASE or RUN) takes effect on the next cycle: DOMAIN_RESET=all 1, CLK_EN=0, LOCKED=0, state goes to PLL_RST. Lock loss does not increment RETRY_CNT.
- A single shared counter of width $clog2(max(all cycle params, NUM_CH*STAGGER)+1) clears on every state change.
- GATE_REQ is honoured only as defined under Configuration. Outside RUN it is ignored.
- RESET asserted mid-sequence returns the block to reset values on the next edge, regardless of state.

## Timing
- LOCK to lock_s latency is 2 cycles. Lock loss to DOMAIN_RESET=1 is at most 3 cycles after LOCK falls.
- Best-case sequence from RESET deassert to RUN: RESET_PULSE + 2 (sync) + 1 + LOCK_FILTER + NUM_CH*STAGGER cycles.
- All outputs are registered. No combinational path from any input to any output.

## Configuration
- PLL_SUP_ICEGATE_EN defined: GATE_REQ is registered. In RUN, CLK_EN[i] = ~GATE_REQ_q[i], giving one cycle of latency from GATE_REQ to CLK_EN. DOMAIN_RESET is unaffected by gating.
- PLL_SUP_ICEGATE_EN undefined: GATE_REQ is unused and CLK_EN is all 1 in RELEASE and RUN.

## Structure
- Package pll_sup_pkg holds the state enum (PLL_RST=0, WAIT_LOCK=1, FILTER=2, RELEASE=3, RUN=4, FAIL=5) and the counter-width function.
- One sub-module, pll_sup_sync, implements the 2-flop synchroniser for LOCK.

## Test plan
All scenarios use the default parameters.
- LOCK rises 10 cycles after the PLL_RESET fall and stays high -> LOCKED rises 2+1+16 cycles after LOCK. DOMAIN_RESET[0..2] fall at +8/+16/+24 after that. STATE=RUN.
- LOCK held 0 -> three timeouts, 64 cycles each. RETRY_CNT goes 1, 2, then FAIL=1 with PLL_RESET=1. FAIL stays until RESET.
- LOCK glitches low once at FILTER count 10 -> STATE returns to WAIT_LOCK, then requalifies with 16 fresh cycles. RETRY_CNT unchanged.
- LOCK drops in RUN -> within 3 cycles DOMAIN_RESET=3'b111, CLK_EN=0, LOCKED=0, STATE=PLL_RST. Full re-sequence follows.
- With PLL_SUP_ICEGATE_EN defined, in RUN: GATE_REQ=3'b010 -> CLK_EN=3'b101 one cycle later. GATE_REQ toggled in RELEASE -> ignored.
- RESET pulsed mid-RELEASE, after DOMAIN_RESET[0] has fallen -> all outputs return to reset values on the next edge.
